// File: rtl/gcd_pkg.sv
// -----------------------------------------------------------------------------
// gcd_pkg
// Shared definitions for the parametrised GCD engine: FSM state encoding and
// the algorithm-select constants used for the MODE parameter.
// -----------------------------------------------------------------------------
package gcd_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } gcd_state_t;

   localparam int GCD_SUB = 0;  // subtractive Euclid
   localparam int GCD_BIN = 1;  // binary (Stein)

endpackage

// File: rtl/gcd_step_unit.sv
// -----------------------------------------------------------------------------
// gcd_step_unit
// Combinational single-step of the GCD iteration.
// Ports:
//   a, b          current operand registers
//   a_next/b_next operand values after one step (only meaningful when step=1)
//   eq            a == b
//   zero          a == 0 or b == 0
//   shift_common  binary mode: both operands even, common factor 2 removed
//   step          this cycle performs an iteration (neither zero nor equal)
// -----------------------------------------------------------------------------
module gcd_step_unit
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MODE  = GCD_SUB
) (
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] a_next,
   output logic [WIDTH-1:0] b_next,
   output logic             eq,
   output logic             zero,
   output logic             shift_common,
   output logic             step
);

   logic a_gt;

   always_comb begin
      a_next       = a;
      b_next       = b;
      shift_common = 1'b0;
      zero         = (a == '0) || (b == '0);
      eq           = (a == b);
      step         = !zero && !eq;
      a_gt         = (a > b);

      if (MODE == GCD_BIN) begin
         if (!a[0] && !b[0]) begin
            a_next       = a >> 1;
            b_next       = b >> 1;
            shift_common = 1'b1;
         end else if (!a[0]) begin
            a_next = a >> 1;
         end else if (!b[0]) begin
            b_next = b >> 1;
         end else if (a_gt) begin
            a_next = a - b;
         end else begin
            b_next = b - a;
         end
      end else begin
         // Larger minus smaller, so the subtraction never wraps.
         if (a_gt) begin
            a_next = a - b;
         end else begin
            b_next = b - a;
         end
      end
   end

endmodule

// File: rtl/gcd_engine_param.sv
// -----------------------------------------------------------------------------
// gcd_engine_param
// Parametrised GCD engine (subtractive Euclid or binary Stein) with
// valid/ready handshakes, zero-operand handling, a saturating iteration
// counter and a synchronous abort.
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; valid is never withdrawn by the engine before its transfer, and the
// engine holds gcd_out/iter_count stable while out_valid && !out_ready.
//
// Ports:
//   clk, rst              clock, asynchronous active-high reset
//   in_valid/in_ready     operand handshake (ready only in IDLE)
//   a_in, b_in            operands
//   abort                 synchronous job drop, honoured in RUN only
//   out_valid/out_ready   result handshake (valid only in DONE)
//   gcd_out               result
//   iter_count            step cycles used for the last result
//   busy                  high while iterating
// -----------------------------------------------------------------------------
module gcd_engine_param
   import gcd_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int MODE  = GCD_SUB,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a_in,
   input  logic [WIDTH-1:0] b_in,
   input  logic             abort,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] gcd_out,
   output logic [CNT_W-1:0] iter_count,
   output logic             busy
);

   localparam int KW = $clog2(WIDTH + 1);

   gcd_state_t state, state_next;

   logic [WIDTH-1:0] a_q, b_q;
   logic [KW-1:0]    k_q;
   logic [CNT_W-1:0] cnt_work;  // running count for the job in flight
   logic [WIDTH-1:0] gcd_q;
   logic [CNT_W-1:0] cnt_out;   // published count, survives aborts

   logic [WIDTH-1:0] a_next, b_next;
   logic             eq, zero, shift_common, step;
   logic             accept, finish;

   gcd_step_unit #(
      .WIDTH (WIDTH),
      .MODE  (MODE)
   ) u_step (
      .a            (a_q),
      .b            (b_q),
      .a_next       (a_next),
      .b_next       (b_next),
      .eq           (eq),
      .zero         (zero),
      .shift_common (shift_common),
      .step         (step)
   );

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_next;
      end
   end

   // ---------------- FSM: next state / decodes ----------------
   always_comb begin
      state_next = state;
      accept     = 1'b0;
      finish     = 1'b0;
      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               accept     = 1'b1;
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_next = ST_IDLE;
            end else if (zero || eq) begin
               finish     = 1'b1;
               state_next = ST_DONE;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_next = ST_IDLE;
            end
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // ---------------- Datapath ----------------
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_q      <= '0;
         b_q      <= '0;
         k_q      <= '0;
         cnt_work <= '0;
         gcd_q    <= '0;
         cnt_out  <= '0;
      end else if (accept) begin
         a_q      <= a_in;
         b_q      <= b_in;
         k_q      <= '0;
         cnt_work <= '0;
      end else if (state == ST_RUN && !abort) begin
         if (finish) begin
            // A|B picks the nonzero operand when one is zero, and A when equal.
            gcd_q   <= (a_q | b_q) << k_q;
            cnt_out <= cnt_work;
         end else if (step) begin
            a_q <= a_next;
            b_q <= b_next;
            k_q <= k_q + KW'(shift_common);
            if (cnt_work != '1) begin
               cnt_work <= cnt_work + 1'b1;
            end
         end
      end
   end

   // in_ready stays low while reset is held so nothing is accepted during it.
   assign in_ready   = (state == ST_IDLE) && !rst;
   assign busy       = (state == ST_RUN);
   assign out_valid  = (state == ST_DONE);
   assign gcd_out    = gcd_q;
   assign iter_count = cnt_out;

endmodule
